// File: rtl/serial_pkg.sv
// Shared constants for the serial_port UART console: register map, STATUS bit
// positions and the FSM state encoding used by both the TX and RX engines.
package serial_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_RX_AVAIL  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_TX_IDLE   = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FRAME_ERR = 4;
    localparam int STAT_LOOPBACK  = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: the head entry is visible combinationally on o_dout.
// A push while full is still accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/serial_port.sv
// Bus-attached 8N1 UART console with TX/RX FIFOs and a polled STATUS word.
// Define SERIAL_LOOPBACK_EN to feed txd back into the receiver internally.
module serial_port
    import serial_pkg::*;
#(
    parameter int CLK_DIV  = 16,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr,
    input  logic [15:0] bus_in,
    input  logic        DI,
    input  logic        DO,
    output logic [15:0] bus_out,
    input  logic        rxd,
    output logic        txd
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

    logic        w_tx_push, w_tx_pop, w_tx_empty, w_tx_full, w_tx_bit_end, w_tx_idle;
    logic [7:0]  w_tx_head;
    logic        w_rx_push, w_rx_pop, w_rx_empty, w_rx_full, w_rx_in, w_rx_stop_sample;
    logic [7:0]  w_rx_head;
    logic        w_status_rd;
    logic [15:0] w_status;
    logic        w_unused;

    uart_state_t r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd;

    uart_state_t r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic        r_overrun, r_frame_err;

    assign w_unused = ^{bus_in[15:8], rxd};

    assign w_tx_push   = DI && (addr == ADDR_DATA);
    assign w_rx_pop    = DO && (addr == ADDR_DATA) && !w_rx_empty;
    assign w_status_rd = DO && (addr == ADDR_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_din   (bus_in[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_din   (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    // Popping at the end of STOP chains frames without an idle bit in between.
    assign w_tx_bit_end = (r_tx_cnt == BIT_END);
    assign w_tx_pop     = !w_tx_empty &&
                          ((r_tx_state == IDLE) || ((r_tx_state == STOP) && w_tx_bit_end));
    assign w_tx_idle    = (r_tx_state == IDLE) && w_tx_empty;
    assign txd          = r_txd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_cnt   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head;
                            r_txd      <= 1'b0;
                            r_tx_state <= START;
                        end else begin
                            r_tx_state <= IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_LOOPBACK_EN
    assign w_rx_in = r_txd;
`else
    assign w_rx_in = rxd;
`endif

    assign w_rx_stop_sample = (r_rx_state == STOP) && (r_rx_cnt == BIT_END);
    assign w_rx_push        = w_rx_stop_sample && r_rx_s2;

    // r_rx_s3 only holds the previous synchronised level for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1 <= w_rx_in;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            case (r_rx_state)
                IDLE: begin
                    if (!r_rx_s2 && r_rx_s3) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= START;
                    end
                end
                START: begin
                    if (r_rx_cnt == HALF_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? IDLE : DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= STOP;
                        else                  r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // A new error on the same edge as a STATUS read takes priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rx_push && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
            else if (w_status_rd)                     r_overrun <= 1'b0;
            if (w_rx_stop_sample && !r_rx_s2) r_frame_err <= 1'b1;
            else if (w_status_rd)              r_frame_err <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_RX_AVAIL]  = !w_rx_empty;
        w_status[STAT_TX_FULL]   = w_tx_full;
        w_status[STAT_TX_IDLE]   = w_tx_idle;
        w_status[STAT_OVERRUN]   = r_overrun;
        w_status[STAT_FRAME_ERR] = r_frame_err;
`ifdef SERIAL_LOOPBACK_EN
        w_status[STAT_LOOPBACK]  = 1'b1;
`endif
    end

    always_comb begin
        bus_out = 16'h0000;
        if (DO) begin
            if (addr == ADDR_STATUS)  bus_out = w_status;
            else if (!w_rx_empty)     bus_out = {8'h00, w_rx_head};
        end
    end

endmodule

// File: tb/tb_serial_port.sv
// Directed self-checking bench for serial_port (CLK_DIV=16, 8-deep FIFOs);
// builds with or without SERIAL_LOOPBACK_EN.
module tb_serial_port;

`ifdef SERIAL_LOOPBACK_EN
    localparam logic [15:0] LB = 16'h8000;
`else
    localparam logic [15:0] LB = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        addr = 1'b0;
    logic [15:0] bus_in = 16'h0000;
    logic        DI = 1'b0;
    logic        DO = 1'b0;
    logic [15:0] bus_out;
    logic        rxd = 1'b1;
    logic        txd;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0 = 0;
    logic [15:0] rd;
    logic [15:0] exp16;

    serial_port #(.CLK_DIV(16), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .bus_in  (bus_in),
        .DI      (DI),
        .DO      (DO),
        .bus_out (bus_out),
        .rxd     (rxd),
        .txd     (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < c0 + n) tick();
    endtask

    task automatic bus_write(input logic a, input logic [15:0] d);
        addr = a; bus_in = d; DI = 1'b1;
        tick();
        DI = 1'b0;
        $display("[TB] write addr=%0d data=%h", a, d);
    endtask

    task automatic bus_read(input logic a, output logic [15:0] d);
        addr = a; DO = 1'b1;
        #1;
        d = bus_out;
        tick();
        DO = 1'b0;
        $display("[TB] read  addr=%0d data=%h", a, d);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(16);
        end
        rxd = stop_bit;
        tick(16);
        rxd = 1'b1;
        tick(4);
        $display("[TB] rx frame data=%h stop=%b", b, stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick();
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
        tests++;
        if (bus_out !== 16'h0000) begin fails++; $display("FAIL idle_bus_out: got %h want 0000", bus_out); end
        exp16 = 16'h0004 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL reset_status: got %h want %h", rd, exp16); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] pat;
        logic       e;
        int         bad;
        pat = 8'h55;
        bad = 0;
        bus_write(1'b0, 16'hAB55);
        c0 = cyc;
        for (int n = 0; n < 160; n++) begin
            wait_cyc(n);
            if (n == 0)         e = 1'b1;
            else if (n <= 16)   e = 1'b0;
            else if (n <= 144)  e = pat[(n - 17) / 16];
            else                e = 1'b1;
            tests++;
            if (txd !== e) begin
                fails++;
                $display("FAIL tx_bit cycle %0d: got %b want %b", n, txd, e);
            end
        end
        wait_cyc(160);
        exp16 = LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL tx_busy_status c160: got %h want %h", rd, exp16); end
        exp16 = 16'h0004 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL tx_idle_status c161: got %h want %h", rd, exp16); end
    endtask

    task automatic test_back_to_back();
        bus_write(1'b0, 16'h0001);
        c0 = cyc;
        bus_write(1'b0, 16'h00FF);
        wait_cyc(24);
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL b2b_byte1_bit0: got %b want 1", txd); end
        wait_cyc(40);
        tests++;
        if (txd !== 1'b0) begin fails++; $display("FAIL b2b_byte1_bit1: got %b want 0", txd); end
        wait_cyc(160);
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL b2b_stop: got %b want 1", txd); end
        wait_cyc(161);
        tests++;
        if (txd !== 1'b0) begin fails++; $display("FAIL b2b_start2: got %b want 0", txd); end
        wait_cyc(185);
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL b2b_byte2_bit0: got %b want 1", txd); end
        wait_cyc(330);
        exp16 = 16'h0004 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL b2b_idle: got %h want %h", rd, exp16); end
    endtask

    task automatic test_tx_full();
        bus_write(1'b0, 16'h0000);
        c0 = cyc;
        for (int i = 1; i < 10; i++) bus_write(1'b0, 16'(i));
        exp16 = 16'h0002 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL tx_full_status: got %h want %h", rd, exp16); end
        wait_cyc(1440);
        exp16 = LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL tx_drain_busy c1440: got %h want %h", rd, exp16); end
        exp16 = 16'h0004 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL tx_drop_idle c1441: got %h want %h", rd, exp16); end
    endtask

    task automatic test_rx_basic();
        send_frame(8'hC3, 1'b1);
        tick(2);
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0005) begin fails++; $display("FAIL rx_avail: got %h want 0005", rd); end
        bus_read(1'b0, rd);
        tests++;
        if (rd !== 16'h00C3) begin fails++; $display("FAIL rx_data: got %h want 00c3", rd); end
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0004) begin fails++; $display("FAIL rx_empty_after: got %h want 0004", rd); end
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < 9; i++) send_frame(8'(8'hA0 + i), 1'b1);
        tick(2);
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h000D) begin fails++; $display("FAIL overrun_status: got %h want 000d", rd); end
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0005) begin fails++; $display("FAIL overrun_cleared: got %h want 0005", rd); end
        for (int i = 0; i < 8; i++) begin
            exp16 = 16'(8'hA0 + i);
            bus_read(1'b0, rd);
            tests++;
            if (rd !== exp16) begin fails++; $display("FAIL rx_order %0d: got %h want %h", i, rd, exp16); end
        end
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0004) begin fails++; $display("FAIL rx_drained: got %h want 0004", rd); end
    endtask

    task automatic test_rx_errors();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0004) begin fails++; $display("FAIL glitch_status: got %h want 0004", rd); end
        send_frame(8'h77, 1'b0);
        tick(2);
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0014) begin fails++; $display("FAIL frame_err_status: got %h want 0014", rd); end
        bus_read(1'b0, rd);
        tests++;
        if (rd !== 16'h0000) begin fails++; $display("FAIL frame_err_data: got %h want 0000", rd); end
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h0004) begin fails++; $display("FAIL frame_err_cleared: got %h want 0004", rd); end
    endtask

    task automatic test_reset_mid_frame();
        bus_write(1'b0, 16'h0000);
        c0 = cyc;
        wait_cyc(30);
        tests++;
        if (txd !== 1'b0) begin fails++; $display("FAIL midframe_txd: got %b want 0", txd); end
        reset = 1'b1;
        #2;
        tests++;
        if (txd !== 1'b1) begin fails++; $display("FAIL async_reset_txd: got %b want 1", txd); end
        tick();
        reset = 1'b0;
        tick();
        exp16 = 16'h0004 | LB;
        bus_read(1'b1, rd);
        tests++;
        if (rd !== exp16) begin fails++; $display("FAIL post_reset_status: got %h want %h", rd, exp16); end
    endtask

`ifdef SERIAL_LOOPBACK_EN
    task automatic test_loopback();
        bus_write(1'b0, 16'h005A);
        c0 = cyc;
        wait_cyc(164);
        bus_read(1'b0, rd);
        tests++;
        if (rd !== 16'h005A) begin fails++; $display("FAIL loopback_data: got %h want 005a", rd); end
        bus_read(1'b1, rd);
        tests++;
        if (rd !== 16'h8004) begin fails++; $display("FAIL loopback_status: got %h want 8004", rd); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SERIAL_LOOPBACK_EN
        test_loopback();
`else
        test_tx_frame();
        test_back_to_back();
        test_tx_full();
        test_rx_basic();
        test_rx_overrun();
        test_rx_errors();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
